patgen: RTL and testbench
=========================

# patgen

Pixel pattern generator sitting directly downstream of the sync generator in the display pipeline. It consumes the sync generator's HSYNC/VSYNC/preDE/VRSTART outputs, tracks the active-pixel coordinate, and drives 24-bit RGB plus DE and sync signals re-aligned one clock later, ready for the display output stage. Four selectable test patterns are supported, with a frame counter for animated patterns.

## Interface
- No parameters. Active sizes come from RESOL: 0 = 640x480, 1 = 800x600, 2 = 1024x768, 3 = 1280x1024.
- DCLK  in  1  dot clock.
- DRST_X  in  1  reset; asynchronous, active-low.
- RESOL  in  2  resolution select; latched at frame start.
- PSEL  in  2  pattern select; latched at frame start.
- VRSTART  in  1  from sync generator; high for one whole line before the back porch.
- DSP_preDE  in  1  from sync generator; high one cycle ahead of the active pixel.
- DSP_HSYNC_X  in  1  from sync generator; active-low.
- DSP_VSYNC_X  in  1  from sync generator; active-low.
- DSP_DE  out  1  data enable, equal to DSP_preDE delayed 1 cycle.
- DSP_HSYNC_OUT_X  out  1  DSP_HSYNC_X delayed 1 cycle.
- DSP_VSYNC_OUT_X  out  1  DSP_VSYNC_X delayed 1 cycle.
- DSP_R, DSP_G, DSP_B  out  8 each  pixel colour; 0 whenever DSP_DE = 0.

## Operation
- Reset (DRST_X = 0, asynchronous) sets the following:
  - DSP_DE = 0, DSP_R/G/B = 0.
  - DSP_HSYNC_OUT_X = 1, DSP_VSYNC_OUT_X = 1.
  - X = 0, Y = 0, FRAME = 0.
  - Latched PSEL = 0 and latched RESOL = 0.
  - Bar counter = 0, bar index = 0, vrstart_d = 0.
- Frame start is a VRSTART rising edge, detected with a registered vrstart_d. On that cycle:
  - latch PSEL and RESOL;
  - clear Y;
  - increment FRAME (8 bits, wraps 255 -> 0).
- X (11 bits): X <= preDE ? X+1 : 0.
- Y (11 bits): increments on the cycle DSP_preDE = 0 while DSP_DE = 1 (falling edge of the active line).
  - Frame start takes priority over this increment if both occur together.
- Bar logic:
  - Bar width BW = 80/100/128/160 for RESOL 0/1/2/3.
  - The bar counter counts during preDE, wraps at BW-1, and increments the 3-bit bar index.
  - The bar index saturates at 7.
  - Both bar counter and bar index clear when preDE = 0.
- Patterns (latched PSEL), with colour computed from the current X/Y/bar index on preDE cycles:
  - 0, colour bars: R = {8{~i[1]}}, G = {8{~i[2]}}, B = {8{~i[0]}}. Order is white, yellow, cyan, green, magenta, red, blue, black.
  - 1, moving gray ramp: R = G = B = X[7:0] + FRAME (mod 256).
  - 2, checker of 32x32 squares: white (FF,FF,FF) when X[5]^Y[5]^FRAME[6], else black.
  - 3, grid: white when any of X == 0, X == W-1, Y == 0, Y == H-1, X[5:0] == 0, Y[5:0] == 0; else (00,00,80). W and H come from latched RESOL.
- All outputs are registered.
- PSEL/RESOL changes mid-frame have no effect until the next frame start.

## Timing
- Latency: outputs lag inputs by exactly 1 DCLK. The RGB sample for coordinate X appears on the cycle after DSP_preDE was high with that X.
- The first active pixel of each line has X = 0; the last has X = W-1. Bar 7 therefore ends exactly at W-1 for all RESOL.
- The first active line after frame start has Y = 0.
- Sync outputs are pure 1-cycle delays, independent of pattern logic.
- Reset released mid-frame:
  - DE/sync outputs follow inputs from the next clock.
  - Y counts from 0 until the next frame start.
  - PSEL = 0 is in effect until the next frame start.
- preDE pulses longer than W are not clipped. X continues to 11-bit wrap and bar index stays at 7.

## Test plan
- Reset behaviour: assert DRST_X low mid-line -> outputs go asynchronously (no clock edge needed) to DE = 0, RGB = 0, HSYNC_OUT_X = VSYNC_OUT_X = 1.
- Colour bars at RESOL = 0, PSEL = 0, full 640x480 frame -> pixels 0-79 = FFFFFF, 80-159 = FFFF00, ..., 560-639 = 000000; RGB = 0 outside DE; DE/HSYNC/VSYNC outputs equal inputs delayed 1 cycle.
- Moving gray ramp at PSEL = 1, 3 frames -> on frame with FRAME = 3, pixel X = 300 is 0x2F (300 mod 256 + 3) on all channels.
- Checker at PSEL = 2 with FRAME = 1 -> pixel (0,0) black, (32,0) white, (32,32) black; after 64 frame starts, (0,0) is white.
- Grid at RESOL = 2, PSEL = 3:
  - (0,5), (1023,5), (64,5), (5,767) are white;
  - (5,5) is 000080.
- Mid-frame select change: switch PSEL 0 -> 1 on line 100 -> remainder of frame stays bars; gray ramp from the next VRSTART rise. Y = 0 on the first active line; FRAME increments once per VRSTART pulse, not per cycle.

Source files
------------

// File: rtl/patgen_if.sv
`default_nettype none
// ============================================================================
// Module   : patgen_if
// Brief    : Sync-generator inputs and display-stage outputs of the pattern generator.
// Revision : 1.0
// ============================================================================
interface patgen_if;
  logic       VRSTART;
  logic       DSP_preDE;
  logic       DSP_HSYNC_X;
  logic       DSP_VSYNC_X;
  logic       DSP_DE;
  logic       DSP_HSYNC_OUT_X;
  logic       DSP_VSYNC_OUT_X;
  logic [7:0] DSP_R;
  logic [7:0] DSP_G;
  logic [7:0] DSP_B;

  modport master (
    output VRSTART, DSP_preDE, DSP_HSYNC_X, DSP_VSYNC_X,
    input  DSP_DE, DSP_HSYNC_OUT_X, DSP_VSYNC_OUT_X, DSP_R, DSP_G, DSP_B
  );

  modport slave (
    input  VRSTART, DSP_preDE, DSP_HSYNC_X, DSP_VSYNC_X,
    output DSP_DE, DSP_HSYNC_OUT_X, DSP_VSYNC_OUT_X, DSP_R, DSP_G, DSP_B
  );
endinterface
`default_nettype wire

// File: rtl/patgen.sv
`default_nettype none
// ============================================================================
// Module   : patgen
// Brief    : Four-pattern RGB test generator, re-aligning DE/syncs by one DCLK.
// Revision : 1.0
// ============================================================================
module patgen (
  input  logic       DCLK,
  input  logic       DRST_X,
  input  logic [1:0] RESOL,
  input  logic [1:0] PSEL,
  patgen_if.slave    sif
);

  logic        r_vrstart_d;
  logic [1:0]  r_psel;
  logic [1:0]  r_resol;
  logic [10:0] r_x;
  logic [10:0] r_y;
  logic [7:0]  r_frame;
  logic [7:0]  r_bar_cnt;
  logic [2:0]  r_bar_idx;
  logic        r_de;
  logic        r_hsync_x;
  logic        r_vsync_x;
  logic [23:0] r_rgb;

  logic        w_frame_start;
  logic [7:0]  w_bw;
  logic [10:0] w_w;
  logic [10:0] w_h;
  logic [7:0]  w_gray;
  logic        w_grid_on;
  logic [23:0] w_pix;

  assign w_frame_start = sif.VRSTART & ~r_vrstart_d;

  always_comb begin
    w_bw = 8'd80;
    w_w  = 11'd640;
    w_h  = 11'd480;
    case (r_resol)
      2'd1: begin w_bw = 8'd100; w_w = 11'd800;  w_h = 11'd600;  end
      2'd2: begin w_bw = 8'd128; w_w = 11'd1024; w_h = 11'd768;  end
      2'd3: begin w_bw = 8'd160; w_w = 11'd1280; w_h = 11'd1024; end
      default: ;
    endcase
  end

  always_comb begin
    w_gray    = r_x[7:0] + r_frame;
    w_grid_on = (r_x == 11'd0) || (r_x == w_w - 11'd1) ||
                (r_y == 11'd0) || (r_y == w_h - 11'd1) ||
                (r_x[5:0] == 6'd0) || (r_y[5:0] == 6'd0);
    w_pix     = 24'h000000;
    case (r_psel)
      // Bar index bits map straight onto inverted colour channels
      2'd0:    w_pix = {{8{~r_bar_idx[1]}}, {8{~r_bar_idx[2]}}, {8{~r_bar_idx[0]}}};
      2'd1:    w_pix = {3{w_gray}};
      2'd2:    w_pix = (r_x[5] ^ r_y[5] ^ r_frame[6]) ? 24'hFFFFFF : 24'h000000;
      default: w_pix = w_grid_on ? 24'hFFFFFF : 24'h000080;
    endcase
  end

  always_ff @(posedge DCLK or negedge DRST_X) begin
    if (!DRST_X) begin
      r_vrstart_d <= 1'b0;
      r_psel      <= 2'd0;
      r_resol     <= 2'd0;
      r_x         <= 11'd0;
      r_y         <= 11'd0;
      r_frame     <= 8'd0;
      r_bar_cnt   <= 8'd0;
      r_bar_idx   <= 3'd0;
      r_de        <= 1'b0;
      r_hsync_x   <= 1'b1;
      r_vsync_x   <= 1'b1;
      r_rgb       <= 24'h000000;
    end else begin
      r_vrstart_d <= sif.VRSTART;
      r_de        <= sif.DSP_preDE;
      r_hsync_x   <= sif.DSP_HSYNC_X;
      r_vsync_x   <= sif.DSP_VSYNC_X;
      r_x         <= sif.DSP_preDE ? r_x + 11'd1 : 11'd0;

      if (w_frame_start) begin
        r_psel  <= PSEL;
        r_resol <= RESOL;
        r_y     <= 11'd0;
        r_frame <= r_frame + 8'd1;
      end else if (!sif.DSP_preDE && r_de) begin
        r_y <= r_y + 11'd1;
      end

      if (sif.DSP_preDE) begin
        if (r_bar_cnt == w_bw - 8'd1) begin
          r_bar_cnt <= 8'd0;
          if (r_bar_idx != 3'd7) r_bar_idx <= r_bar_idx + 3'd1;
        end else begin
          r_bar_cnt <= r_bar_cnt + 8'd1;
        end
      end else begin
        r_bar_cnt <= 8'd0;
        r_bar_idx <= 3'd0;
      end

      r_rgb <= sif.DSP_preDE ? w_pix : 24'h000000;
    end
  end

  assign sif.DSP_DE          = r_de;
  assign sif.DSP_HSYNC_OUT_X = r_hsync_x;
  assign sif.DSP_VSYNC_OUT_X = r_vsync_x;
  assign sif.DSP_R           = r_rgb[23:16];
  assign sif.DSP_G           = r_rgb[15:8];
  assign sif.DSP_B           = r_rgb[7:0];

endmodule
`default_nettype wire

// File: tb/tb_patgen.sv
`default_nettype none
// ============================================================================
// Module   : tb_patgen
// Brief    : Directed, self-checking bench for patgen.
// Revision : 1.0
// ============================================================================
module tb_patgen;

  typedef struct {
    int          resol;
    int          x;
    logic [23:0] exp;
  } bar_vec_t;

  logic       DCLK   = 1'b0;
  logic       DRST_X = 1'b1;
  logic [1:0] RESOL  = 2'd0;
  logic [1:0] PSEL   = 2'd0;

  patgen_if pif ();

  patgen dut (
    .DCLK   (DCLK),
    .DRST_X (DRST_X),
    .RESOL  (RESOL),
    .PSEL   (PSEL),
    .sif    (pif)
  );

  always #5 DCLK = ~DCLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] rgb;
  assign rgb = {pif.DSP_R, pif.DSP_G, pif.DSP_B};

  // Reference for the pure one-cycle delay of DE and syncs
  logic e_de = 1'b0;
  logic e_hs = 1'b1;
  logic e_vs = 1'b1;
  always @(posedge DCLK or negedge DRST_X) begin
    if (!DRST_X) begin
      e_de <= 1'b0;
      e_hs <= 1'b1;
      e_vs <= 1'b1;
    end else begin
      e_de <= pif.DSP_preDE;
      e_hs <= pif.DSP_HSYNC_X;
      e_vs <= pif.DSP_VSYNC_X;
    end
  end

  logic [23:0] line_pix [0:2047];
  int          ox = 0;
  bar_vec_t    bars [$];
  int          widths [4] = '{640, 800, 1024, 1280};

  task automatic chk(input string name, input logic [23:0] got, input logic [23:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %06h expected %06h", name, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge DCLK);
    chk("sync_delay", {21'd0, pif.DSP_DE, pif.DSP_HSYNC_OUT_X, pif.DSP_VSYNC_OUT_X},
        {21'd0, e_de, e_hs, e_vs});
    if (!pif.DSP_DE) chk("rgb_blank", rgb, 24'h000000);
    if (pif.DSP_DE) begin
      if (ox < 2048) line_pix[ox] = rgb;
      ox++;
    end else begin
      ox = 0;
    end
  endtask

  task automatic do_line(input int act, input bit vr, input bit vs);
    for (int i = 0; i < act + 12; i++) begin
      tick();
      pif.VRSTART     = vr;
      pif.DSP_VSYNC_X = ~vs;
      pif.DSP_HSYNC_X = (i >= 4);
      pif.DSP_preDE   = (i >= 8) && (i < 8 + act);
    end
  endtask

  task automatic frame_start();
    do_line(0, 1'b1, 1'b1);
    do_line(0, 1'b0, 1'b0);
  endtask

  task automatic short_lines(input int n);
    for (int i = 0; i < n; i++) do_line(1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    tick();
    DRST_X = 1'b0;
    tick();
    tick();
    DRST_X = 1'b1;
  endtask

  initial begin
    bars.push_back('{0,   0, 24'hFFFFFF});
    bars.push_back('{0,  79, 24'hFFFFFF});
    bars.push_back('{0,  80, 24'hFFFF00});
    bars.push_back('{0, 159, 24'hFFFF00});
    bars.push_back('{0, 160, 24'h00FFFF});
    bars.push_back('{0, 240, 24'h00FF00});
    bars.push_back('{0, 320, 24'hFF00FF});
    bars.push_back('{0, 400, 24'hFF0000});
    bars.push_back('{0, 480, 24'h0000FF});
    bars.push_back('{0, 559, 24'h0000FF});
    bars.push_back('{0, 560, 24'h000000});
    bars.push_back('{0, 639, 24'h000000});
    bars.push_back('{0, 655, 24'h000000});
    bars.push_back('{1,  99, 24'hFFFFFF});
    bars.push_back('{1, 100, 24'hFFFF00});
    bars.push_back('{1, 699, 24'h0000FF});
    bars.push_back('{1, 700, 24'h000000});
    bars.push_back('{2, 127, 24'hFFFFFF});
    bars.push_back('{2, 128, 24'hFFFF00});
    bars.push_back('{2, 895, 24'h0000FF});
    bars.push_back('{2, 896, 24'h000000});
    bars.push_back('{3, 159, 24'hFFFFFF});
    bars.push_back('{3, 160, 24'hFFFF00});
    bars.push_back('{3, 1119, 24'h0000FF});
    bars.push_back('{3, 1120, 24'h000000});

    pif.VRSTART     = 1'b0;
    pif.DSP_preDE   = 1'b0;
    pif.DSP_HSYNC_X = 1'b1;
    pif.DSP_VSYNC_X = 1'b1;

    // Asynchronous reset before any clock edge
    #2 DRST_X = 1'b0;
    #1;
    chk("reset_sync", {21'd0, pif.DSP_DE, pif.DSP_HSYNC_OUT_X, pif.DSP_VSYNC_OUT_X}, 24'h000003);
    chk("reset_rgb", rgb, 24'h000000);
    tick();
    tick();
    DRST_X = 1'b1;

    // Mid-line asynchronous reset
    tick();
    pif.DSP_preDE = 1'b1; pif.DSP_HSYNC_X = 1'b0; pif.DSP_VSYNC_X = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_reset_rgb", rgb, 24'hFFFFFF);
    #2 DRST_X = 1'b0;
    #1;
    chk("midline_reset_sync", {21'd0, pif.DSP_DE, pif.DSP_HSYNC_OUT_X, pif.DSP_VSYNC_OUT_X}, 24'h000003);
    chk("midline_reset_rgb", rgb, 24'h000000);
    tick();
    pif.DSP_preDE = 1'b0; pif.DSP_HSYNC_X = 1'b1; pif.DSP_VSYNC_X = 1'b1;
    DRST_X = 1'b1;

    // Without a frame start the reset selections (bars, 640 wide) stay active
    PSEL = 2'd2; RESOL = 2'd3;
    do_line(200, 1'b0, 1'b0);
    chk("postreset_bar_x0", line_pix[0], 24'hFFFFFF);
    chk("postreset_bar_x79", line_pix[79], 24'hFFFFFF);
    chk("postreset_bar_x80", line_pix[80], 24'hFFFF00);
    chk("postreset_bar_x160", line_pix[160], 24'h00FFFF);

    // Colour bars for every resolution, lines overrun W by 20
    PSEL = 2'd0;
    for (int r = 0; r < 4; r++) begin
      RESOL = 2'(r);
      frame_start();
      do_line(widths[r] + 20, 1'b0, 1'b0);
      chk("bar_line_len", 24'(ox), 24'd0);
      foreach (bars[k]) begin
        if (bars[k].resol == r) chk($sformatf("bars_r%0d_x%0d", r, bars[k].x), line_pix[bars[k].x], bars[k].exp);
      end
    end

    // Moving gray ramp on the frame with FRAME = 3
    do_reset();
    PSEL = 2'd1; RESOL = 2'd0;
    frame_start(); frame_start(); frame_start();
    do_line(640, 1'b0, 1'b0);
    chk("gray_x300", line_pix[300], 24'h2F2F2F);
    chk("gray_x255", line_pix[255], 24'h020202);
    chk("gray_x0", line_pix[0], 24'h030303);

    // Checker
    do_reset();
    PSEL = 2'd2;
    frame_start();
    do_line(64, 1'b0, 1'b0);
    chk("chk_0_0", line_pix[0], 24'h000000);
    chk("chk_31_0", line_pix[31], 24'h000000);
    chk("chk_32_0", line_pix[32], 24'hFFFFFF);
    short_lines(31);
    do_line(64, 1'b0, 1'b0);
    chk("chk_32_32", line_pix[32], 24'h000000);
    chk("chk_0_32", line_pix[0], 24'hFFFFFF);
    for (int f = 0; f < 63; f++) frame_start();
    do_line(64, 1'b0, 1'b0);
    chk("chk_0_0_frame64", line_pix[0], 24'hFFFFFF);

    // Grid at 1024x768
    PSEL = 2'd3; RESOL = 2'd2;
    frame_start();
    do_line(1024, 1'b0, 1'b0);
    chk("grid_5_0", line_pix[5], 24'hFFFFFF);
    short_lines(4);
    do_line(1024, 1'b0, 1'b0);
    chk("grid_0_5", line_pix[0], 24'hFFFFFF);
    chk("grid_1023_5", line_pix[1023], 24'hFFFFFF);
    chk("grid_64_5", line_pix[64], 24'hFFFFFF);
    chk("grid_5_5", line_pix[5], 24'h000080);
    chk("grid_63_5", line_pix[63], 24'h000080);
    short_lines(760);
    do_line(6, 1'b0, 1'b0);
    chk("grid_5_766", line_pix[5], 24'h000080);
    do_line(6, 1'b0, 1'b0);
    chk("grid_5_767", line_pix[5], 24'hFFFFFF);

    // Pattern select change mid-frame
    do_reset();
    PSEL = 2'd0; RESOL = 2'd0;
    frame_start();
    do_line(640, 1'b0, 1'b0);
    chk("midsel_y0_x100", line_pix[100], 24'hFFFF00);
    short_lines(99);
    PSEL = 2'd1;
    do_line(640, 1'b0, 1'b0);
    chk("midsel_y100_x100", line_pix[100], 24'hFFFF00);
    chk("midsel_y100_x300", line_pix[300], 24'h00FF00);
    frame_start();
    do_line(640, 1'b0, 1'b0);
    chk("midsel_next_x100", line_pix[100], 24'h666666);
    chk("midsel_next_x0", line_pix[0], 24'h020202);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
